project_select_ctrl: RTL and testbench
======================================

Name: project_select_ctrl

Overview:
Wishbone-mapped controller that produces the per-project "active" enable lines for the group-submission user area. Each wrapped design tristates its IOs unless its active bit is high. This block sits directly upstream of the user_project_wrapper instances and replaces driving active from raw LA bits. It guarantees break-before-make handover: all projects are off for a programmable gap before the newly selected project is enabled.

Parameters:
NPROJ, 16, number of active lines; ID 0 means "none", so active_o[0] is always 0
BASE_ADDR, 32'h3000_0000, Wishbone base address; 16-byte window
GAP_W, 8, width of the handover gap counter
GAP_DEFAULT, 8, reset value of the GAP register, in cycles

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous, active-high reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge, registered
wbs_dat_o  out  32  read data, registered
active_o  out  NPROJ  one-hot (or all-zero) project enables, registered

Behaviour:
- Reset (sync on wb_rst_i): active_o=0, wbs_ack_o=0, wbs_dat_o=0, cur=0, pending=0, gap=GAP_DEFAULT, FSM=IDLE. Reset mid-handover aborts it; all lines are 0 the next cycle.
- Decode: hit = stb & cyc & (adr[31:4]==BASE_ADDR[31:4]).
  - Outside the window: never ack.
  - Inside the window:
    - 0x0 SELECT: RW, [7:0] pending ID.
    - 0x4 STATUS: RO, [7:0] cur, [15:8] pending, [16] busy.
    - 0x8 GAP: RW, [GAP_W-1:0].
    - 0xC ID: RO, 32'h5053_0001.
  - Unmapped or RO writes are ignored but still acked.
- Handshake: ack <= hit & ~ack. One-cycle ack pulse, one cycle after the request. A held strobe gets a fresh ack every other cycle.
  - dat_o is loaded in the same cycle ack is set, and zeroed when not acking.
  - Writes honour sel: SELECT uses sel[0]; GAP uses sel[0] and, if GAP_W>8, sel[1].
- Select sanitising: a written ID >= NPROJ is stored as 0.
- FSM:
  - IDLE: active_o = onehot(cur), with cur=0 giving all-zero.
    - A SELECT write with value != cur sets pending, clears active_o the next cycle, loads cnt=max(gap,1) and goes to DRAIN.
    - A write equal to cur is a no-op.
  - DRAIN: active_o=0, cnt decrements each cycle. At cnt==1, go to ENABLE.
    - A SELECT write during DRAIN updates pending only; cnt is not restarted.
  - ENABLE (one cycle): cur<=pending, active_o<=onehot(pending), back to IDLE. If pending==0, all lines stay 0.
- busy = (FSM != IDLE).
- Gap: active_o is all-zero for exactly max(gap,1)+1 cycles between the old line falling and the new line rising.
- GAP write during DRAIN takes effect only at the next handover.
- Invariant: popcount(active_o) <= 1 every cycle.

Optional Feature:
Macro PROJSEL_LA_OVERRIDE_EN.
- When defined: adds inputs la_force_i (1) and la_sel_i (8).
  - While la_force_i=1, the handover FSM takes its target from la_sel_i (sanitised as above) instead of the SELECT register.
  - A change of la_sel_i starts a handover exactly like a SELECT write.
  - The rising and falling edges of la_force_i also trigger a handover if the effective target differs from cur.
  - STATUS[17] reads la_force_i.
- When not defined: the ports are absent, STATUS[17]=0, and only Wishbone controls selection.

Decomposition:
- Package projsel_pkg holds:
  - register offsets REG_SELECT/REG_STATUS/REG_GAP/REG_ID;
  - ID constant 32'h5053_0001;
  - FSM state enum {IDLE, DRAIN, ENABLE};
  - the STATUS bit positions.
- One natural sub-module, projsel_handover: FSM, gap counter, cur/pending and the one-hot active_o.
- The top holds Wishbone decode, registers and readback.

Test Plan:
- Reset, read 0xC, then 0x4 -> ack after 1 cycle, dat 32'h5053_0001, then 32'h0; active_o=0.
- GAP=3, write SELECT=1 -> after handover active_o=16'h0002, busy drops; active_o=0 for 4 cycles before the rise.
- cur=1, write SELECT=5 -> bit1 falls the cycle after ack, 4 zero cycles, then 16'h0020; never two bits set.
- Write SELECT=20 (>= NPROJ) -> pending=0, active_o=0 after drain, STATUS[7:0]=0.
- During DRAIN (1->5) write SELECT=2 -> gap is not restarted, final active_o=16'h0004.
- Assert wb_rst_i mid-DRAIN -> the next cycle active_o=0, cur=0, GAP=8; an access to adr 0x3000_0010 -> no ack.

Source files
------------

// File: rtl/projsel_pkg.sv
// projsel_pkg: register map, ID constant, handover FSM states and STATUS layout for project_select_ctrl
package projsel_pkg;
  localparam logic [3:0] REG_SELECT = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_GAP = 4'h8;
  localparam logic [3:0] REG_ID = 4'hC;
  localparam logic [31:0] PROJ_ID = 32'h5053_0001;
  localparam int ST_CUR_LSB = 0;
  localparam int ST_PEND_LSB = 8;
  localparam int ST_BUSY = 16;
  localparam int ST_FORCE = 17;
  typedef enum logic [1:0] {IDLE, DRAIN, ENABLE} state_t;
  function automatic logic [7:0] sanitize_id(input logic [7:0] id, input int nproj);
    return (int'(id) < nproj) ? id : 8'd0;
  endfunction
endpackage

// File: rtl/projsel_handover.sv
// projsel_handover: break-before-make handover FSM driving the one-hot project enables
module projsel_handover
  import projsel_pkg::*;
#(
  parameter int NPROJ = 16,
  parameter int GAP_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       target_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic [7:0]       cur_o,
  output logic [7:0]       pending_o,
  output logic             busy_o,
  output logic [NPROJ-1:0] active_o
);
  state_t state_q;
  logic [GAP_W-1:0] cnt_q;
  logic [7:0] cur_q, pending_q;
  logic [NPROJ-1:0] active_q;
  // Any mismatch between target and current project drops all lines, waits the gap, then enables the target
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cur_q <= '0;
      pending_q <= '0;
      active_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (target_i != cur_q) begin
          pending_q <= target_i;
          active_q <= '0;
          cnt_q <= (gap_i == '0) ? GAP_W'(1) : gap_i;
          state_q <= DRAIN;
        end
        DRAIN: begin
          pending_q <= target_i;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == GAP_W'(1)) state_q <= ENABLE;
        end
        ENABLE: begin
          cur_q <= pending_q;
          active_q <= ({{(NPROJ-1){1'b0}}, 1'b1} << pending_q) & {{(NPROJ-1){1'b1}}, 1'b0};
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cur_o = cur_q;
  assign pending_o = pending_q;
  assign busy_o = state_q != IDLE;
  assign active_o = active_q;
endmodule

// File: rtl/project_select_ctrl.sv
// project_select_ctrl: Wishbone-mapped project selector; optional LA override via PROJSEL_LA_OVERRIDE_EN
module project_select_ctrl
  import projsel_pkg::*;
#(
  parameter int NPROJ = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int GAP_W = 8,
  parameter int GAP_DEFAULT = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [NPROJ-1:0] active_o
`ifdef PROJSEL_LA_OVERRIDE_EN
  ,
  input  logic             la_force_i,
  input  logic [7:0]       la_sel_i
`endif
);
  logic hit, acc, wr, wr_gap, busy, la_force, unused_ok;
  logic [1:0] off;
  logic [7:0] sel_q, target, la_id, cur, pend;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [31:0] be, status, rdata;
  assign hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc = hit & ~wbs_ack_o;
  assign wr = acc & wbs_we_i;
  assign off = wbs_adr_i[3:2];
  assign be = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wr_gap = wr && off == REG_GAP[3:2];
  assign gap_d = wr_gap ? (gap_q & ~be[GAP_W-1:0]) | (wbs_dat_i[GAP_W-1:0] & be[GAP_W-1:0]) : gap_q;
  assign unused_ok = ^{wbs_adr_i[1:0], be, wbs_dat_i};
`ifdef PROJSEL_LA_OVERRIDE_EN
  assign la_force = la_force_i;
  assign la_id = sanitize_id(la_sel_i, NPROJ);
`else
  assign la_force = 1'b0;
  assign la_id = 8'd0;
`endif
  assign target = la_force ? la_id : sel_q;
  projsel_handover #(.NPROJ(NPROJ), .GAP_W(GAP_W)) u_handover (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .target_i(target),
    .gap_i(gap_q),
    .cur_o(cur),
    .pending_o(pend),
    .busy_o(busy),
    .active_o(active_o)
  );
  // Readback mux for the four registers of the window
  always_comb begin
    status = '0;
    status[ST_CUR_LSB +: 8] = cur;
    status[ST_PEND_LSB +: 8] = pend;
    status[ST_BUSY] = busy;
    status[ST_FORCE] = la_force;
    rdata = off == REG_SELECT[3:2] ? {24'd0, sel_q} :
            off == REG_STATUS[3:2] ? status :
            off == REG_GAP[3:2] ? 32'(gap_q) : PROJ_ID;
  end
  // Single-cycle ack pulse with registered read data and byte-enabled register writes
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      sel_q <= '0;
      gap_q <= GAP_W'(GAP_DEFAULT);
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= acc ? rdata : '0;
      if (wr && off == REG_SELECT[3:2] && wbs_sel_i[0]) sel_q <= sanitize_id(wbs_dat_i[7:0], NPROJ);
      gap_q <= gap_d;
    end
  end
endmodule

// File: tb/tb_project_select_ctrl.sv
// tb_project_select_ctrl: table, directed and random checks of project_select_ctrl
module tb_project_select_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic clk = 0, rst = 1, stb = 0, cyc_i = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, dat_w = 0;
  logic ack;
  logic [31:0] dat_r;
  logic [15:0] active;
  always #5 clk = ~clk;
  project_select_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc_i), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .active_o(active)
  );
  int n_chk = 0, n_fail = 0, cyc = 0, gap_m = 8, ack_cyc = 0, wb_lat = 0;
  int rise_cyc = -1, fall_cyc = -1, streak = 0, last_run = 0;
  logic [15:0] prev = 0;
  logic [7:0] sel_m = 0;
  typedef struct {
    logic [31:0] adr;
    logic we;
    logic [31:0] dat;
    logic [3:0] sel;
    logic exp_ack;
    logic chk_dat;
    logic [31:0] exp_dat;
  } vec_t;
  vec_t tbl[15];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] onehot(input logic [7:0] id);
    logic [15:0] v = 0;
    if (id != 0 && id < 16) v[id[3:0]] = 1'b1;
    return v;
  endfunction
  function automatic logic [7:0] clean(input logic [7:0] id);
    return id < 16 ? id : 8'd0;
  endfunction
  function automatic int min_zeros();
    return (gap_m < 1 ? 1 : gap_m) + 1;
  endfunction
  always @(negedge clk) begin
    n_chk++;
    if ($countones(active) > 1) begin
      n_fail++;
      $display("FAIL onehot: active_o=%h, expected at most one bit set", active);
    end
    if (active != 0 && prev == 0) begin
      rise_cyc = cyc;
      last_run = streak;
      n_chk++;
      if (streak < min_zeros()) begin
        n_fail++;
        $display("FAIL gap_min: %0d zero cycles before rise, expected >= %0d", streak, min_zeros());
      end
    end
    if (active == 0 && prev != 0) fall_cyc = cyc;
    streak = (active == 0) ? streak + 1 : 0;
    prev = active;
  end
  task automatic wb(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                    output logic got, output logic [31:0] q);
    int start;
    start = cyc;
    adr = a; we = w; dat_w = d; sel = s; stb = 1; cyc_i = 1; got = 0; q = 0;
    for (int i = 0; i < 3 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      got = ack;
      q = dat_r;
    end
    ack_cyc = cyc;
    wb_lat = cyc - start;
    stb = 0; cyc_i = 0; we = 0;
    @(negedge clk);
  endtask
  task automatic wr_sel(input logic [7:0] v);
    logic g;
    logic [31:0] q;
    wb(BASE, 1, {24'd0, v}, 4'hF, g, q);
    chk("sel_wr_ack", g, 1);
  endtask
  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic g;
    logic [31:0] q;
    wb(a, 0, 0, 4'hF, g, q);
    chk({name, "_ack"}, g, 1);
    chk(name, q, exp);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic g;
    logic [31:0] q;
    int c;
    tbl[0] = '{BASE + 32'hC, 0, 0, 4'hF, 1, 1, 32'h5053_0001};
    tbl[1] = '{BASE + 32'h4, 0, 0, 4'hF, 1, 1, 32'h0};
    tbl[2] = '{BASE + 32'h8, 0, 0, 4'hF, 1, 1, 32'd8};
    tbl[3] = '{BASE + 32'h8, 1, 32'd3, 4'hF, 1, 0, 0};
    tbl[4] = '{BASE + 32'h8, 0, 0, 4'hF, 1, 1, 32'd3};
    tbl[5] = '{BASE + 32'h8, 1, 32'd7, 4'h0, 1, 0, 0};
    tbl[6] = '{BASE + 32'h8, 0, 0, 4'hF, 1, 1, 32'd3};
    tbl[7] = '{BASE + 32'hC, 1, 32'h0, 4'hF, 1, 0, 0};
    tbl[8] = '{BASE + 32'hC, 0, 0, 4'hF, 1, 1, 32'h5053_0001};
    tbl[9] = '{BASE + 32'h4, 1, 32'hFFFF, 4'hF, 1, 0, 0};
    tbl[10] = '{BASE + 32'h4, 0, 0, 4'hF, 1, 1, 32'h0};
    tbl[11] = '{BASE + 32'h10, 0, 0, 4'hF, 0, 1, 32'h0};
    tbl[12] = '{32'h2FFF_FFFC, 0, 0, 4'hF, 0, 1, 32'h0};
    tbl[13] = '{BASE + 32'h8, 1, 32'hFFFF_FF05, 4'h1, 1, 0, 0};
    tbl[14] = '{BASE + 32'h8, 0, 0, 4'hF, 1, 1, 32'd5};
    repeat (3) @(negedge clk);
    chk("rst_active", active, 0);
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat_r, 0);
    rst = 0;
    @(negedge clk);
    foreach (tbl[i]) begin
      wb(tbl[i].adr, tbl[i].we, tbl[i].dat, tbl[i].sel, g, q);
      chk($sformatf("tbl%0d_ack", i), g, tbl[i].exp_ack);
      if (tbl[i].chk_dat) chk($sformatf("tbl%0d_dat", i), q, tbl[i].exp_dat);
      if (tbl[i].exp_ack) chk($sformatf("tbl%0d_lat", i), wb_lat, 1);
    end
    chk("tbl_active", active, 0);
    wb(BASE + 32'h8, 1, 32'd3, 4'h1, g, q);
    gap_m = 3;
    wr_sel(1);
    c = ack_cyc;
    repeat (10) @(negedge clk);
    chk("h01_active", active, 16'h0002);
    chk("h01_rise_lat", rise_cyc - c, 5);
    rd("h01_status", BASE + 32'h4, 32'h0000_0101);
    wr_sel(5);
    c = ack_cyc;
    repeat (10) @(negedge clk);
    chk("h15_fall_lat", fall_cyc - c, 1);
    chk("h15_zero_run", last_run, 4);
    chk("h15_rise_lat", rise_cyc - c, 5);
    chk("h15_active", active, 16'h0020);
    wr_sel(20);
    repeat (10) @(negedge clk);
    chk("h20_active", active, 0);
    rd("h20_status", BASE + 32'h4, 32'h0);
    rd("h20_select", BASE, 32'h0);
    wr_sel(1);
    repeat (10) @(negedge clk);
    chk("md_pre_active", active, 16'h0002);
    wr_sel(5);
    c = ack_cyc;
    wr_sel(2);
    repeat (10) @(negedge clk);
    chk("md_active", active, 16'h0004);
    chk("md_zero_run", last_run, 4);
    chk("md_rise_lat", rise_cyc - c, 5);
    wr_sel(5);
    rst = 1;
    @(negedge clk);
    chk("rd_active", active, 0);
    rst = 0;
    gap_m = 8;
    sel_m = 0;
    repeat (20) @(negedge clk);
    chk("rd_active_held", active, 0);
    rd("rd_status", BASE + 32'h4, 32'h0);
    rd("rd_gap", BASE + 32'h8, 32'd8);
    wb(BASE + 32'h10, 0, 0, 4'hF, g, q);
    chk("rd_oow_ack", g, 0);
    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 3);
      if (op == 0) begin
        logic [7:0] v;
        logic [3:0] s;
        v = 8'($urandom_range(0, 6));
        s = 4'($urandom_range(0, 15));
        wb(BASE + 32'h8, 1, ($urandom() & 32'hFFFF_FF00) | {24'd0, v}, s, g, q);
        chk("rnd_gap_ack", g, 1);
        if (s[0]) gap_m = v;
        rd("rnd_gap", BASE + 32'h8, gap_m);
      end else if (op == 1) begin
        logic [7:0] v;
        logic [3:0] s;
        v = 8'($urandom_range(0, 31));
        s = ($urandom_range(0, 3) == 0) ? 4'hE : 4'h1;
        wb(BASE, 1, {24'd0, v}, s, g, q);
        chk("rnd_sel_ack", g, 1);
        if (s[0]) sel_m = clean(v);
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          v = 8'($urandom_range(0, 31));
          wb(BASE, 1, {24'd0, v}, 4'hF, g, q);
          chk("rnd_sel2_ack", g, 1);
          sel_m = clean(v);
        end
        repeat (3 * (min_zeros() + 1) + 6) @(negedge clk);
        chk("rnd_active", active, onehot(sel_m));
        rd("rnd_status", BASE + 32'h4, {16'd0, sel_m, sel_m});
      end else if (op == 2) begin
        logic [31:0] a;
        a = $urandom();
        if (a[31:4] == BASE[31:4]) a = a ^ 32'h8000_0000;
        wb(a, $urandom_range(0, 1) == 1, $urandom(), 4'hF, g, q);
        chk("rnd_oow_ack", g, 0);
      end else begin
        rd("rnd_id", BASE + 32'hC, 32'h5053_0001);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
